// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift-register command sequencer:
// shift register ctrl codes and sequencer FSM states.
package shift_reg_pkg;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHR  = 2'b01;
  localparam logic [1:0] CTRL_SHL  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] shift_code(input logic dir);
    return dir ? CTRL_SHL : CTRL_SHR;
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter holding the remaining shift count of the active
// command; load has priority over dec and dec never goes below zero.
module shift_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);
  assign one   = (count_reg == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Command sequencer for an 8-bit universal shift register: optional parallel
// load followed by N shifts, then a done pulse; abortable while running.
module shift_reg_seq_ctrl
  import shift_reg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_load,
  input  logic              i_cmd_dir,
  input  logic [CNT_W-1:0]  i_cmd_cnt,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic              i_abort,
  output logic [1:0]        o_sr_ctrl,
  output logic [DATA_W-1:0] o_sr_d,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  state_t            state_reg, state_next;
  logic              dir_reg, dir_next;
  logic [DATA_W-1:0] sr_d_reg, sr_d_next;
  logic [1:0]        sr_ctrl_reg, sr_ctrl_next;
  logic              ready_reg, busy_reg, done_reg, aborted_reg, aborted_next;

  logic              cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic [CNT_W-1:0]  cnt_load_val, cnt_value;

  shift_cnt #(.CNT_W(CNT_W)) u_shift_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    sr_d_next    = sr_d_reg;
    aborted_next = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = i_cmd_cnt;
    cnt_dec      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // i_abort has no effect here, so valid+abort still starts a command
        if (i_cmd_valid && ready_reg) begin
          dir_next = i_cmd_dir;
          cnt_load = 1'b1;
          if (i_cmd_load) begin
            sr_d_next  = i_cmd_data;
            state_next = ST_LOAD;
          end else if (i_cmd_cnt != '0) begin
            state_next = ST_SHIFT;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end else if (cnt_zero) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_one) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it
    case (state_next)
      ST_LOAD:  sr_ctrl_next = CTRL_LOAD;
      ST_SHIFT: sr_ctrl_next = shift_code(dir_next);
      default:  sr_ctrl_next = CTRL_HOLD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      dir_reg     <= 1'b0;
      sr_d_reg    <= '0;
      sr_ctrl_reg <= CTRL_HOLD;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      sr_d_reg    <= sr_d_next;
      sr_ctrl_reg <= sr_ctrl_next;
      ready_reg   <= (state_next == ST_IDLE);
      busy_reg    <= (state_next != ST_IDLE);
      done_reg    <= (state_next == ST_DONE);
      aborted_reg <= aborted_next;
    end
  end

  assign o_cmd_ready = ready_reg;
  assign o_sr_ctrl   = sr_ctrl_reg;
  assign o_sr_d      = sr_d_reg;
  assign o_busy      = busy_reg;
  assign o_done      = done_reg;
  assign o_aborted   = aborted_reg;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Directed bench: sequencer driving a behavioural 8-bit universal shift
// register (zero fill), 20 ns clock, hand-computed expectations.
module tb_shift_reg_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       i_cmd_load;
  logic       i_cmd_dir;
  logic [3:0] i_cmd_cnt;
  logic [7:0] i_cmd_data;
  logic       i_abort;
  logic [1:0] o_sr_ctrl;
  logic [7:0] o_sr_d;
  logic       o_busy;
  logic       o_done;
  logic       o_aborted;
  logic [7:0] sr_q;

  int total = 0;
  int bad   = 0;

  always #10 i_clk = ~i_clk;

  shift_reg_seq_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_load  (i_cmd_load),
    .i_cmd_dir   (i_cmd_dir),
    .i_cmd_cnt   (i_cmd_cnt),
    .i_cmd_data  (i_cmd_data),
    .i_abort     (i_abort),
    .o_sr_ctrl   (o_sr_ctrl),
    .o_sr_d      (o_sr_d),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted)
  );

  // Universal shift register driven by the sequencer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr_q <= 8'h00;
    end else begin
      case (o_sr_ctrl)
        2'b01:   sr_q <= {1'b0, sr_q[7:1]};
        2'b10:   sr_q <= {sr_q[6:0], 1'b0};
        2'b11:   sr_q <= o_sr_d;
        default: sr_q <= sr_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int n_load, n_shift, n_wrong, n_done, n_abort, n_busy;
  int done_cyc, abort_cyc, ready_cyc;

  // Issue one command and trace it; cycle k=1 is the first cycle after acceptance.
  task automatic run_cmd(input logic load, input logic dir, input logic [3:0] cnt,
                         input logic [7:0] data, input int abort_at, input logic abort_w_valid);
    int w;
    logic [1:0] shift_ctrl;
    shift_ctrl = dir ? 2'b10 : 2'b01;
    n_load = 0; n_shift = 0; n_wrong = 0; n_done = 0; n_abort = 0; n_busy = 0;
    done_cyc = -1; abort_cyc = -1; ready_cyc = -1;
    @(negedge i_clk);
    w = 0;
    while (!o_cmd_ready && w < 50) begin
      @(negedge i_clk);
      w++;
    end
    i_cmd_valid = 1'b1;
    i_cmd_load  = load;
    i_cmd_dir   = dir;
    i_cmd_cnt   = cnt;
    i_cmd_data  = data;
    i_abort     = abort_w_valid;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    i_cmd_data  = 8'h00;
    i_cmd_cnt   = 4'h0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge i_clk);
      i_abort = (k == abort_at);
      if (o_sr_ctrl == 2'b11) n_load++;
      else if (o_sr_ctrl == shift_ctrl) n_shift++;
      else if (o_sr_ctrl != 2'b00) n_wrong++;
      if (o_busy) n_busy++;
      if (o_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (o_aborted) begin
        n_abort++;
        if (abort_cyc < 0) abort_cyc = k;
      end
      if (o_cmd_ready) begin
        ready_cyc = k;
        break;
      end
    end
    i_abort = 1'b0;
    $display("cmd load=%0d dir=%0d cnt=%0d data=%02h abort_at=%0d: loads=%0d shifts=%0d done@%0d abort@%0d ready@%0d q=%02h",
             load, dir, cnt, data, abort_at, n_load, n_shift, done_cyc, abort_cyc, ready_cyc, sr_q);
  endtask

  initial begin
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_load = 1'b0; i_cmd_dir = 1'b0;
    i_cmd_cnt = 4'h0; i_cmd_data = 8'h00; i_abort = 1'b0;
    #35;
    check("rst_ctrl", o_sr_ctrl, 2'b00);
    check("rst_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_aborted", o_aborted, 0);
    check("rst_q", sr_q, 8'h00);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    $display("reset released");

    // Load only
    run_cmd(1'b1, 1'b0, 4'd0, 8'hF1, 0, 1'b0);
    check("ld0_loads", n_load, 1);
    check("ld0_shifts", n_shift + n_wrong, 0);
    check("ld0_done_cyc", done_cyc, 2);
    check("ld0_ndone", n_done, 1);
    check("ld0_ready", ready_cyc, 3);
    check("ld0_q", sr_q, 8'hF1);

    // Load then 3 left shifts
    run_cmd(1'b1, 1'b1, 4'd3, 8'hF1, 0, 1'b0);
    check("shl3_loads", n_load, 1);
    check("shl3_shifts", n_shift, 3);
    check("shl3_wrong", n_wrong, 0);
    check("shl3_done_cyc", done_cyc, 5);
    check("shl3_ready", ready_cyc, 6);
    check("shl3_q", sr_q, 8'h88);

    // Empty command
    run_cmd(1'b0, 1'b0, 4'd0, 8'h00, 0, 1'b0);
    check("nop_done_cyc", done_cyc, 1);
    check("nop_ready", ready_cyc, 2);
    check("nop_activity", n_load + n_shift + n_wrong, 0);
    check("nop_q", sr_q, 8'h88);

    run_cmd(1'b1, 1'b0, 4'd2, 8'hA5, 0, 1'b0);
    check("shr2_done_cyc", done_cyc, 4);
    check("shr2_q", sr_q, 8'h29);
    check("shr2_sr_d", o_sr_d, 8'hA5);

    // Maximum count, no wrap
    run_cmd(1'b0, 1'b0, 4'd15, 8'h00, 0, 1'b0);
    check("max_shifts", n_shift, 15);
    check("max_wrong", n_wrong + n_load, 0);
    check("max_done_cyc", done_cyc, 16);
    check("max_ndone", n_done, 1);
    check("max_ready", ready_cyc, 17);
    check("max_busy", n_busy, 16);
    check("max_q", sr_q, 8'h00);

    // Abort on the 3rd shift cycle (k=1 is LOAD)
    run_cmd(1'b1, 1'b0, 4'd8, 8'hFF, 4, 1'b0);
    check("abt_shifts", n_shift, 3);
    check("abt_ndone", n_done, 0);
    check("abt_nabort", n_abort, 1);
    check("abt_cyc", abort_cyc, 5);
    check("abt_ready", ready_cyc, 5);
    check("abt_q", sr_q, 8'h1F);

    // Abort while idle
    @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check("idle_abt_aborted", o_aborted, 0);
    check("idle_abt_busy", o_busy, 0);
    check("idle_abt_ready", o_cmd_ready, 1);
    $display("idle abort: aborted=%0d busy=%0d", o_aborted, o_busy);

    // Abort together with valid in IDLE: command accepted
    run_cmd(1'b0, 1'b1, 4'd1, 8'h00, 0, 1'b1);
    check("va_shifts", n_shift, 1);
    check("va_done_cyc", done_cyc, 2);
    check("va_nabort", n_abort, 0);
    check("va_q", sr_q, 8'h3E);

    // Abort during DONE is ignored
    run_cmd(1'b0, 1'b0, 4'd0, 8'h00, 1, 1'b0);
    check("dabt_ndone", n_done, 1);
    check("dabt_nabort", n_abort, 0);
    check("dabt_ready", ready_cyc, 2);

    // Reset in the middle of a shift run
    @(negedge i_clk);
    i_cmd_valid = 1'b1; i_cmd_load = 1'b1; i_cmd_dir = 1'b0;
    i_cmd_cnt = 4'd8; i_cmd_data = 8'h3C;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("mid_ctrl_shr", o_sr_ctrl, 2'b01);
    #3 i_rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", o_sr_ctrl, 2'b00);
    check("mid_rst_ready", o_cmd_ready, 1);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_aborted", o_aborted, 0);
    check("mid_rst_q", sr_q, 8'h00);
    $display("mid-shift reset: ctrl=%0b busy=%0d q=%02h", o_sr_ctrl, o_busy, sr_q);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_cmd(1'b1, 1'b1, 4'd1, 8'h5A, 0, 1'b0);
    check("post_rst_done_cyc", done_cyc, 3);
    check("post_rst_ndone", n_done, 1);
    check("post_rst_q", sr_q, 8'hB4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
